uart_tx_fifo: RTL

Parametrised UART transmitter with an integrated transmit FIFO and a ready/valid input handshake. It supports configurable data width, optional odd or even parity, and configurable stop-bit length. It sends back-to-back frames with no idle gap while the FIFO holds data. It is driven by the shared baud-rate tick generator (s_tick at oversample rate) and feeds the serial line pin.

---
 rtl/uart_tx_fifo_if.sv | 11 +
 rtl/uart_tx_fifo.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// Ready/valid word interface feeding the UART transmit FIFO.
interface uart_tx_fifo_if #(
    parameter int DBIT = 8
);
    logic [DBIT-1:0] data_in;
    logic            in_valid;
    logic            in_ready;

    modport master (output data_in, output in_valid, input in_ready);
    modport slave  (input data_in, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO; frames are sent
// back-to-back while words are queued.
module uart_tx_fifo #(
    parameter int DBIT       = 8,
    parameter int OVERSAMPLE = 16,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        s_tick,
    uart_tx_fifo_if.slave               in_if,
    output logic                        data_out,
    output logic                        tx_busy,
    output logic                        tx_done_tick,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int TMAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int BW   = $clog2(DBIT);

    localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);
    localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
    localparam logic          PODD     = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DBIT-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            push, pop, empty;
    logic [DBIT-1:0] head;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [DBIT-1:0] sh_q, sh_d;
    logic            par_q, par_d;
    logic            line_d, load, done;

    assign in_if.in_ready = (count != FULL);
    assign push       = in_if.in_valid & in_if.in_ready;
    assign empty      = (count == '0);
    assign head       = mem[rd_ptr];
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_if.data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            par_q    <= 1'b0;
            data_out <= 1'b1;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            par_q    <= par_d;
            data_out <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        line_d  = 1'b1;
        load    = 1'b0;
        done    = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: load = !empty;
            START: begin
                line_d = 1'b0;
                if (s_tick) begin
                    if (tick_q == OS_LAST) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = DATA;
                    end else tick_d = tick_q + 1'b1;
                end
            end
            DATA: begin
                line_d = sh_q[0];
                if (s_tick) begin
                    if (tick_q == OS_LAST) begin
                        tick_d = '0;
                        sh_d   = sh_q >> 1;
                        if (bit_q == BIT_LAST) begin
                            bit_d   = '0;
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end else bit_d = bit_q + 1'b1;
                    end else tick_d = tick_q + 1'b1;
                end
            end
            PARITY: begin
                line_d = par_q;
                if (s_tick) begin
                    if (tick_q == OS_LAST) begin
                        tick_d  = '0;
                        state_d = STOP;
                    end else tick_d = tick_q + 1'b1;
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (tick_q == SB_LAST) begin
                        done    = 1'b1;
                        tick_d  = '0;
                        state_d = IDLE;
                        load    = !empty;
                    end else tick_d = tick_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Parity is fixed at pop time so the shifting data cannot disturb it.
        if (load) begin
            pop     = 1'b1;
            sh_d    = head;
            par_d   = (^head) ^ PODD;
            tick_d  = '0;
            bit_d   = '0;
            state_d = START;
        end
    end

    assign tx_busy      = (state_q != IDLE);
    assign tx_done_tick = done & ~reset;
endmodule
